mm_mac_datapath: RTL and testbench

Arithmetic datapath directly downstream of `MM_control`. Takes the A and x operand words read from the operand RAMs at `addr_A`/`addr_x`, multiplies them, and accumulates one dot product per output element under the `control`/`result_en` strobes. It then issues a write of each finished element to the P RAM at the matching `addr_P`. It also tracks completed writes and flags the end of a full matrix product.

---
 rtl/mm_mac_datapath.sv | 150 +++++++++++++++
 tb/tb_mm_mac_datapath.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_mac_datapath.sv
// mm_mac_datapath: multiply-accumulate stage behind MM_control.
// Define MM_MAC_SAT_EN for a saturating accumulator (wraps otherwise).
module mm_mac_datapath #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 18,
    parameter int P_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              control,
    input  logic              result_en,
    input  logic [3:0]        addr_P,
    input  logic [DATA_W-1:0] data_A,
    input  logic [DATA_W-1:0] data_x,
    output logic              p_we,
    output logic [3:0]        p_addr,
    output logic [ACC_W-1:0]  p_data,
    output logic              ovf,
    output logic              done,
    output logic [4:0]        wr_count
);

    localparam int PROD_W = 2 * DATA_W;

    // S0: strobes aligned with the address cycle
    logic             ctl_s0_q, ctl_s0_d;
    logic             res_s0_q, res_s0_d;
    logic [3:0]       addr_s0_q, addr_s0_d;

    // S1: strobes aligned with the registered product
    logic             ctl_s1_q, ctl_s1_d;
    logic             res_s1_q, res_s1_d;
    logic [3:0]       addr_s1_q, addr_s1_d;
    logic [ACC_W-1:0] prod_q, prod_d;

    // S2: accumulator and P RAM write port
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             p_we_q, p_we_d;
    logic [3:0]       p_addr_q, p_addr_d;
    logic [ACC_W-1:0] p_data_q, p_data_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [4:0]       wr_count_q, wr_count_d;

    logic [PROD_W-1:0] prod_full;
    logic [ACC_W:0]    acc_sum;
    logic              carry;
    logic [ACC_W-1:0]  sum;
    logic [4:0]        wr_inc;

    // S0/S1 next state: delay strobes to meet the RAM read data
    always_comb begin
        ctl_s0_d  = control;
        res_s0_d  = result_en;
        addr_s0_d = addr_P;
        ctl_s1_d  = ctl_s0_q;
        res_s1_d  = res_s0_q;
        addr_s1_d = addr_s0_q;
        prod_full = PROD_W'(data_A) * PROD_W'(data_x);
        prod_d    = ACC_W'(prod_full);
    end

    // S0/S1 pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_s0_q  <= 1'b0;
            res_s0_q  <= 1'b0;
            addr_s0_q <= '0;
            ctl_s1_q  <= 1'b0;
            res_s1_q  <= 1'b0;
            addr_s1_q <= '0;
            prod_q    <= '0;
        end else begin
            ctl_s0_q  <= ctl_s0_d;
            res_s0_q  <= res_s0_d;
            addr_s0_q <= addr_s0_d;
            ctl_s1_q  <= ctl_s1_d;
            res_s1_q  <= res_s1_d;
            addr_s1_q <= addr_s1_d;
            prod_q    <= prod_d;
        end
    end

    // S2 accumulate: a first term restarts the sum from the product
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, prod_q};
        carry   = !ctl_s1_q && acc_sum[ACC_W];
        if (ctl_s1_q) begin
            sum = prod_q;
        end else begin
`ifdef MM_MAC_SAT_EN
            sum = carry ? '1 : acc_sum[ACC_W-1:0];
`else
            sum = acc_sum[ACC_W-1:0];
`endif
        end
    end

    // S2 write port, overflow flag and write counter next state
    always_comb begin
        acc_d      = sum;
        p_we_d     = 1'b0;
        p_addr_d   = p_addr_q;
        p_data_d   = p_data_q;
        ovf_d      = ovf_q | carry;
        done_d     = 1'b0;
        wr_count_d = wr_count_q;
        wr_inc     = wr_count_q + 5'd1;
        if (res_s1_q) begin
            p_we_d   = 1'b1;
            p_addr_d = addr_s1_q;
            p_data_d = sum;
            if (wr_inc == 5'(P_DEPTH)) begin
                done_d     = 1'b1;
                wr_count_d = '0;
            end else begin
                wr_count_d = wr_inc;
            end
        end
    end

    // S2 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            p_we_q     <= 1'b0;
            p_addr_q   <= '0;
            p_data_q   <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            wr_count_q <= '0;
        end else begin
            acc_q      <= acc_d;
            p_we_q     <= p_we_d;
            p_addr_q   <= p_addr_d;
            p_data_q   <= p_data_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign p_we     = p_we_q;
    assign p_addr   = p_addr_q;
    assign p_data   = p_data_q;
    assign ovf      = ovf_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mm_mac_datapath.sv
// tb_mm_mac_datapath: table-driven stimulus with a write scoreboard.
// Runs with ACC_W=16 so the overflow case is reachable.
module tb_mm_mac_datapath;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int PD = 16;

    logic          clk;
    logic          rst;
    logic          control;
    logic          result_en;
    logic [3:0]    addr_P;
    logic [DW-1:0] data_A;
    logic [DW-1:0] data_x;
    logic          p_we;
    logic [3:0]    p_addr;
    logic [AW-1:0] p_data;
    logic          ovf;
    logic          done;
    logic [4:0]    wr_count;

    mm_mac_datapath #(
        .DATA_W (DW),
        .ACC_W  (AW),
        .P_DEPTH(PD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .control  (control),
        .result_en(result_en),
        .addr_P   (addr_P),
        .data_A   (data_A),
        .data_x   (data_x),
        .p_we     (p_we),
        .p_addr   (p_addr),
        .p_data   (p_data),
        .ovf      (ovf),
        .done     (done),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ctl;
        logic          res;
        logic [3:0]    addr;
        logic [7:0]    a;
        logic [7:0]    x;
        logic [15:0]   want;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic [4:0]  cnt;
        logic        dn;
        logic        ov;
        int          when;
    } exp_t;

    exp_t       sbq[$];
    exp_t       me;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         wcnt_m = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] pa = 8'd0;
    logic [7:0] px = 8'd0;
    vec_t       tv[8];

`ifdef MM_MAC_SAT_EN
    localparam logic [15:0] OVF_WANT = 16'd65535;
`else
    localparam logic [15:0] OVF_WANT = 16'd64514;
`endif

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // One term per cycle: strobes now, operands of the previous term now
    task automatic drive(input vec_t v);
        @(negedge clk);
        control   = v.ctl;
        result_en = v.res;
        addr_P    = v.addr;
        data_A    = pa;
        data_x    = px;
        pa        = v.a;
        px        = v.x;
        if (v.res) begin
            exp_t e;
            wcnt_m++;
            e.addr = v.addr;
            e.data = v.want;
            e.dn   = (wcnt_m == PD);
            if (e.dn) wcnt_m = 0;
            e.cnt  = 5'(wcnt_m);
            e.ov   = exp_ovf;
            e.when = cyc + 3;
            sbq.push_back(e);
        end
    endtask

    task automatic flush(input int n);
        repeat (n) begin
            @(negedge clk);
            control   = 1'b0;
            result_en = 1'b0;
            addr_P    = 4'd0;
            data_A    = pa;
            data_x    = px;
            pa        = 8'd0;
            px        = 8'd0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sbq.size(), 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst       = 1'b1;
        control   = 1'b0;
        result_en = 1'b0;
        sbq.delete();
        wcnt_m    = 0;
        exp_ovf   = 1'b0;
        pa        = 8'd0;
        px        = 8'd0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: every write must match the oldest expectation, on time
    always @(negedge clk) begin
        if (p_we === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0d want none",
                         p_addr, p_data);
            end else begin
                me = sbq.pop_front();
                chk("write_cycle", cyc, me.when);
                chk("p_addr", p_addr, me.addr);
                chk("p_data", p_data, me.data);
                chk("wr_count", wr_count, me.cnt);
                chk("done", done, me.dn);
                chk("ovf", ovf, me.ov);
            end
        end else if (cyc > 0) begin
            chk("done_without_write", done, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        control   = 1'b0;
        result_en = 1'b0;
        addr_P    = 4'd0;
        data_A    = 8'd0;
        data_x    = 8'd0;

        // reset held with random inputs
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_outputs",
                {p_we, p_addr, p_data, ovf, done, wr_count}, 0);
            control   = 1'($urandom);
            result_en = 1'($urandom);
            addr_P    = 4'($urandom);
            data_A    = 8'($urandom);
            data_x    = 8'($urandom);
        end
        @(negedge clk);
        chk("reset_outputs_last",
            {p_we, p_addr, p_data, ovf, done, wr_count}, 0);
        rst       = 1'b0;
        control   = 1'b0;
        result_en = 1'b0;
        data_A    = 8'd0;
        data_x    = 8'd0;

        // no control since reset; dot product; single term; discard
        tv[0] = '{ctl: 0, res: 1, addr: 1, a: 3,   x: 4,   want: 12};
        tv[1] = '{ctl: 1, res: 0, addr: 0, a: 1,   x: 5,   want: 0};
        tv[2] = '{ctl: 0, res: 0, addr: 0, a: 2,   x: 6,   want: 0};
        tv[3] = '{ctl: 0, res: 0, addr: 0, a: 3,   x: 7,   want: 0};
        tv[4] = '{ctl: 0, res: 1, addr: 9, a: 4,   x: 8,   want: 70};
        tv[5] = '{ctl: 1, res: 1, addr: 2, a: 255, x: 255, want: 65025};
        tv[6] = '{ctl: 1, res: 0, addr: 0, a: 9,   x: 9,   want: 0};
        tv[7] = '{ctl: 1, res: 1, addr: 5, a: 3,   x: 3,   want: 9};
        for (int i = 0; i < 8; i++) drive(tv[i]);
        drive('{ctl: 1, res: 0, addr: 0, a: 7, x: 7, want: 0});
        drive('{ctl: 0, res: 1, addr: 4, a: 2, x: 2, want: 53});
        flush(1);
        drain();
        chk("ovf_clear_after_table", ovf, 0);

        // full 4x4 product, identity times x[i]=i+1, back to back
        do_reset(1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++)
                    drive('{ctl: (k == 0), res: (k == 3),
                            addr: 4'(r * 4 + c),
                            a: 8'(r == k), x: 8'(k * 4 + c + 1),
                            want: 16'(r * 4 + c + 1)});
        flush(1);
        drain();
        chk("wr_count_wrapped", wr_count, 0);

        // overflow on a two-term accumulation
        do_reset(1);
        exp_ovf = 1'b1;
        drive('{ctl: 1, res: 0, addr: 0, a: 255, x: 255, want: 0});
        drive('{ctl: 0, res: 1, addr: 3, a: 255, x: 255, want: OVF_WANT});
        flush(1);
        drain();
        flush(3);
        chk("ovf_sticky", ovf, 1);
        do_reset(1);
        chk("ovf_cleared_by_rst", ovf, 0);

        // reset between terms 2 and 3 drops the product
        drive('{ctl: 1, res: 0, addr: 7, a: 1, x: 2, want: 0});
        drive('{ctl: 0, res: 0, addr: 7, a: 1, x: 2, want: 0});
        drive('{ctl: 0, res: 0, addr: 7, a: 1, x: 2, want: 0});
        do_reset(1);
        flush(4);
        chk("no_write_after_midreset", wr_count, 0);
        drive('{ctl: 1, res: 0, addr: 6, a: 1, x: 2, want: 0});
        drive('{ctl: 0, res: 0, addr: 6, a: 1, x: 2, want: 0});
        drive('{ctl: 0, res: 0, addr: 6, a: 1, x: 2, want: 0});
        drive('{ctl: 0, res: 1, addr: 6, a: 1, x: 2, want: 8});
        flush(1);
        drain();
        flush(2);
        chk("wr_count_final", wr_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
